instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Downstream consumer of the byte-wide instruction memory in the multicycle MIPS core.
- On a fetch request, issues four consecutive byte addresses starting at the PC and captures the four bytes returned one cycle later.
- Assembles the bytes into one 32-bit instruction word and hands it to the control/decode stage with a one-cycle valid pulse.
- Flags misaligned PCs and supports flush.

Parameters:
- ADDR_W, 6: byte-address width of the instruction memory (64 bytes).
- BIG_ENDIAN, 0: 0 means the byte at PC lands in instr_o[7:0]; 1 means it lands in instr_o[31:24].

Ports:
- clk_i  in  1  core clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- fetch_req_i  in  1  start a fetch at pc_i; sampled only in IDLE.
- flush_i  in  1  abort any fetch in progress.
- pc_i  in  32  byte address of the instruction.
- mem_addr_o  out  ADDR_W  byte address driven to the memory; registered.
- mem_rdata_i  in  8  memory read byte; valid one clock after the address.
- instr_o  out  32  assembled instruction; holds its value until the next completed fetch.
- instr_valid_o  out  1  one-cycle pulse when instr_o is updated.
- busy_o  out  1  high while in RUN.
- misalign_o  out  1  one-cycle pulse when a request is rejected because pc_i[1:0]!=0.

Behaviour:
- Reset (asynchronous): state=IDLE, mem_addr_o=0, instr_o=0, instr_valid_o=0, busy_o=0, misalign_o=0, counters=0, shift register=0. Asserting reset mid-fetch discards the fetch; no valid pulse is produced.
- States: IDLE and RUN. Counters: iss_cnt (0..4) and cap_cnt (0..3).
- IDLE:
  - fetch_req_i=1 with pc_i[1:0]==0 at edge E0 → RUN. mem_addr_o<=pc_i[ADDR_W-1:0], iss_cnt<=1, cap_cnt<=0, base address latched.
  - fetch_req_i=1 with pc_i[1:0]!=0 → stay in IDLE; misalign_o pulses for 1 cycle.
- RUN, address issue:
  - At edges E1..E3: mem_addr_o<=base+iss_cnt, computed modulo 2^ADDR_W (wraps past the top of memory); iss_cnt increments.
  - After E3, mem_addr_o holds base+3.
- RUN, capture:
  - At edge Ek (k=2..5), capture mem_rdata_i as byte k-2 into its lane per BIG_ENDIAN.
  - Capture gating: a read-pending flag delayed one cycle from address issue; capture never occurs in the cycle right after E0.
- Completion, at E5:
  - instr_o is written with the full word.
  - instr_valid_o=1 for the cycle after E5 only.
  - state → IDLE, busy_o=0.
- Latency: valid is high 5 clocks after the request edge. Back-to-back requests give one instruction per 6 cycles, because a request is accepted in the first IDLE cycle after completion.
- Partial bytes go to an internal shift register. instr_o never shows a partially assembled word.
- fetch_req_i while in RUN: ignored, not queued.
- flush_i=1 in RUN: next state IDLE, no valid pulse, instr_o unchanged, busy_o drops the following cycle.
- flush_i and fetch_req_i together in IDLE: flush wins and the request is dropped.
- pc_i is sampled only at acceptance; later changes have no effect.
- Example: memory bytes 08 00 03 20 at addresses 0..3 with BIG_ENDIAN=0 yield 32'h20030008.

Decomposition:
- Package mips_pkg:
  - typedef fetch_state_t {IDLE, RUN}.
  - Constants INSTR_BYTES=4 and MEM_LAT=1.
  - Shared width constants.
- Sub-module byte_assembler:
  - 4-lane shift/lane register with load, clear and endianness control.
  - Produces the word; the FSM commits it to instr_o.

Test Plan:
- Memory bytes 08 00 03 20 at 0..3, pulse fetch_req_i with pc_i=0 → mem_addr_o sequence 0,1,2,3 after E0..E3; instr_o=32'h20030008 and instr_valid_o high exactly in the cycle after E5; busy_o high for 5 cycles.
- pc_i=32'h3C, ADDR_W=6, bytes at 60..63 = ff 00 04 a0 → instr_o=32'ha00400ff. Repeat with pc_i=32'h40 → addresses wrap to 0..3.
- pc_i=32'h2 with fetch_req_i → misalign_o one-cycle pulse, busy_o stays 0, no memory address change, no valid.
- Start a fetch, assert flush_i at E3 → IDLE next cycle, no instr_valid_o, instr_o keeps its previous value. A new request at pc_i=4 then completes with 32'h20040001.
- Hold fetch_req_i high continuously with pc_i stepping 0,4,8 → valid pulses every 6 cycles giving 20030008, 20040001, 2005ffff; requests during RUN are ignored.
- Assert rst_i asynchronously mid-RUN (between edges) → all outputs 0 immediately, state IDLE, no valid after release.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared types and constants for the multicycle MIPS instruction-fetch path.
package mips_pkg;

    // Fetch sequencer states.
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fetch_state_t;

    // Bytes per instruction word and read latency of the byte-wide memory.
    localparam int INSTR_BYTES = 4;
    localparam int MEM_LAT     = 1;

    // Shared widths.
    localparam int BYTE_W    = 8;
    localparam int INSTR_W   = INSTR_BYTES * BYTE_W;
    localparam int ISS_CNT_W = $clog2(INSTR_BYTES + 1);  // counts 0..INSTR_BYTES
    localparam int CAP_CNT_W = $clog2(INSTR_BYTES);      // counts 0..INSTR_BYTES-1

    // A PC is usable only when it points at a word boundary.
    function automatic logic is_word_aligned(input logic [1:0] pc_lsb);
        return (pc_lsb == 2'b00);
    endfunction

endpackage

// File: rtl/byte_assembler.sv
// Shift register that collects instruction bytes in arrival order and
// presents the word as it would look once the current byte is shifted in.
module byte_assembler
    import mips_pkg::*;
#(
    parameter bit BIG_ENDIAN = 1'b0
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               load_i,
    input  logic               clear_i,
    input  logic [BYTE_W-1:0]  byte_i,
    output logic [INSTR_W-1:0] word_o
);

    logic [INSTR_W-1:0] shift_q;
    logic [INSTR_W-1:0] shift_d;

    // Little-endian shifts new bytes in from the top so the first byte ends
    // in the least-significant lane; big-endian shifts in from the bottom so
    // the first byte ends in the most-significant lane.
    if (BIG_ENDIAN) begin : g_big
        always_comb shift_d = {shift_q[INSTR_W-BYTE_W-1:0], byte_i};
    end else begin : g_little
        always_comb shift_d = {byte_i, shift_q[INSTR_W-1:BYTE_W]};
    end

    // The owner commits word_o on the last load, so it already includes byte_i.
    assign word_o = shift_d;

    // Hold partial bytes; clear has priority so a completed or aborted word
    // never leaks into the next fetch.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            shift_q <= '0;
        end else if (clear_i) begin
            shift_q <= '0;
        end else if (load_i) begin
            shift_q <= shift_d;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: reads four consecutive bytes from the byte-wide
// instruction memory, assembles them into a word and hands it to decode with
// a one-cycle valid pulse. Rejects misaligned PCs and supports flush.
module instr_fetch_unit
    import mips_pkg::*;
#(
    parameter int ADDR_W     = 6,
    parameter bit BIG_ENDIAN = 1'b0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              fetch_req_i,
    input  logic              flush_i,
    input  logic [31:0]       pc_i,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic [7:0]        mem_rdata_i,
    output logic [31:0]       instr_o,
    output logic              instr_valid_o,
    output logic              busy_o,
    output logic              misalign_o
);

    fetch_state_t         state_q;
    logic [ADDR_W-1:0]    base_q;
    logic [ADDR_W-1:0]    mem_addr_q;
    logic [ISS_CNT_W-1:0] iss_cnt_q;
    logic [CAP_CNT_W-1:0] cap_cnt_q;
    logic                 iss_vld_q;
    logic [MEM_LAT-1:0]   rd_pipe_q;
    logic [INSTR_W-1:0]   instr_q;
    logic                 valid_q;
    logic                 busy_q;
    logic                 misalign_q;

    logic [ADDR_W-1:0]    mem_addr_d;
    logic [MEM_LAT-1:0]   rd_pipe_d;
    logic [INSTR_W-1:0]   instr_d;
    logic                 rd_pend;
    logic                 iss_more;
    logic                 cap_en;
    logic                 cap_last;
    logic                 asm_clear;

    // Only the low ADDR_W bits of the PC address the 64-byte memory.
    logic pc_hi_unused;
    assign pc_hi_unused = ^pc_i[31:ADDR_W];

    // Next issue address wraps naturally modulo 2^ADDR_W.
    assign mem_addr_d = base_q + ADDR_W'(iss_cnt_q);
    assign iss_more   = (iss_cnt_q < ISS_CNT_W'(INSTR_BYTES));

    // Read-pending flag: an issued address returns data MEM_LAT cycles later,
    // so capture can never happen in the cycle directly after acceptance.
    assign rd_pipe_d  = MEM_LAT'({rd_pipe_q, iss_vld_q});
    assign rd_pend    = rd_pipe_q[MEM_LAT-1];

    assign cap_en     = (state_q == RUN) && !flush_i && rd_pend;
    assign cap_last   = cap_en && (cap_cnt_q == CAP_CNT_W'(INSTR_BYTES - 1));
    assign asm_clear  = (state_q == RUN) && (flush_i || cap_last);

    byte_assembler #(
        .BIG_ENDIAN (BIG_ENDIAN)
    ) u_asm (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .load_i  (cap_en),
        .clear_i (asm_clear),
        .byte_i  (mem_rdata_i),
        .word_o  (instr_d)
    );

    // Fetch sequencer: accepts requests in IDLE, issues addresses and counts
    // captured bytes in RUN, and owns every registered output.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            base_q     <= '0;
            mem_addr_q <= '0;
            iss_cnt_q  <= '0;
            cap_cnt_q  <= '0;
            iss_vld_q  <= 1'b0;
            rd_pipe_q  <= '0;
            instr_q    <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            valid_q    <= 1'b0;
            misalign_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // Flush dominates a simultaneous request.
                    if (!flush_i && fetch_req_i) begin
                        if (is_word_aligned(pc_i[1:0])) begin
                            state_q    <= RUN;
                            busy_q     <= 1'b1;
                            base_q     <= pc_i[ADDR_W-1:0];
                            mem_addr_q <= pc_i[ADDR_W-1:0];
                            iss_cnt_q  <= ISS_CNT_W'(1);
                            cap_cnt_q  <= '0;
                            iss_vld_q  <= 1'b1;
                            rd_pipe_q  <= '0;
                        end else begin
                            misalign_q <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (flush_i) begin
                        state_q   <= IDLE;
                        busy_q    <= 1'b0;
                        iss_cnt_q <= '0;
                        cap_cnt_q <= '0;
                        iss_vld_q <= 1'b0;
                        rd_pipe_q <= '0;
                    end else begin
                        rd_pipe_q <= rd_pipe_d;
                        if (iss_more) begin
                            mem_addr_q <= mem_addr_d;
                            iss_cnt_q  <= iss_cnt_q + ISS_CNT_W'(1);
                            iss_vld_q  <= 1'b1;
                        end else begin
                            iss_vld_q  <= 1'b0;
                        end
                        if (cap_last) begin
                            instr_q   <= instr_d;
                            valid_q   <= 1'b1;
                            state_q   <= IDLE;
                            busy_q    <= 1'b0;
                            iss_cnt_q <= '0;
                            cap_cnt_q <= '0;
                            iss_vld_q <= 1'b0;
                            rd_pipe_q <= '0;
                        end else if (cap_en) begin
                            cap_cnt_q <= cap_cnt_q + CAP_CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign mem_addr_o    = mem_addr_q;
    assign instr_o       = instr_q;
    assign instr_valid_o = valid_q;
    assign busy_o        = busy_q;
    assign misalign_o    = misalign_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit with a byte-wide synchronous
// memory model and a word-level reference model.
module tb_instr_fetch_unit;

    localparam int ADDR_W = 6;
    localparam bit BE     = 1'b0;
    localparam int MEM_SZ = 64;

    logic              clk = 1'b0;
    logic              rst;
    logic              fetch_req;
    logic              flush;
    logic [31:0]       pc;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_rdata;
    logic [31:0]       instr;
    logic              valid;
    logic              busy;
    logic              misalign;

    logic [7:0] mem [MEM_SZ];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Memory returns the addressed byte one clock after the address.
    always @(posedge clk) mem_rdata <= mem[mem_addr];

    instr_fetch_unit #(
        .ADDR_W     (ADDR_W),
        .BIG_ENDIAN (BE)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .fetch_req_i   (fetch_req),
        .flush_i       (flush),
        .pc_i          (pc),
        .mem_addr_o    (mem_addr),
        .mem_rdata_i   (mem_rdata),
        .instr_o       (instr),
        .instr_valid_o (valid),
        .busy_o        (busy),
        .misalign_o    (misalign)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: the word made of the four bytes at pc, pc+1, pc+2, pc+3
    // (modulo memory size), first byte in the low or high lane.
    function automatic logic [31:0] ref_word(input logic [31:0] p);
        logic [31:0] w;
        w = '0;
        for (int i = 0; i < 4; i++) begin
            if (BE) w[31-8*i -: 8] = mem[(p + 32'(i)) % MEM_SZ];
            else    w[8*i +: 8]    = mem[(p + 32'(i)) % MEM_SZ];
        end
        return w;
    endfunction

    function automatic logic [ADDR_W-1:0] ref_addr(input logic [31:0] p, input int i);
        return ADDR_W'((p + 32'(i)) % MEM_SZ);
    endfunction

    // Pulse a request and follow the fetch until valid or a cycle budget runs out.
    task automatic do_fetch(input logic [31:0] p, input bit noise,
                            output logic [31:0] word, output int lat,
                            output int busy_n, output logic [3:0][ADDR_W-1:0] addrs,
                            output bit got);
        word = '0; lat = -1; busy_n = 0; addrs = '0; got = 1'b0;
        fetch_req = 1'b1;
        pc = p;
        tick();
        fetch_req = 1'b0;
        for (int c = 0; c < 12 && !got; c++) begin
            if (busy) busy_n++;
            if (c < 4) addrs[c] = mem_addr;
            if (valid) begin
                got  = 1'b1;
                word = instr;
                lat  = c;
            end else begin
                if (noise && c < 5) begin
                    pc        = $urandom;
                    fetch_req = 1'($urandom_range(0, 1));
                end else begin
                    fetch_req = 1'b0;
                end
                tick();
            end
        end
        fetch_req = 1'b0;
    endtask

    task automatic init_mem();
        for (int i = 0; i < MEM_SZ; i++) mem[i] = 8'(i * 7 + 3);
        mem[0]  = 8'h08; mem[1]  = 8'h00; mem[2]  = 8'h03; mem[3]  = 8'h20;
        mem[4]  = 8'h01; mem[5]  = 8'h00; mem[6]  = 8'h04; mem[7]  = 8'h20;
        mem[8]  = 8'hff; mem[9]  = 8'hff; mem[10] = 8'h05; mem[11] = 8'h20;
        mem[60] = 8'hff; mem[61] = 8'h00; mem[62] = 8'h04; mem[63] = 8'ha0;
    endtask

    task automatic test_reset();
        rst = 1'b1; fetch_req = 1'b0; flush = 1'b0; pc = '0;
        tick(); tick();
        checks++;
        if ({mem_addr, instr, valid, busy, misalign} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: addr=%0d instr=%h v=%b b=%b m=%b, want all 0",
                     mem_addr, instr, valid, busy, misalign);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        logic [31:0] w; int lat, bn; logic [3:0][ADDR_W-1:0] a; bit got;
        do_fetch(32'h0, 1'b0, w, lat, bn, a, got);
        checks++;
        if (got !== 1'b1) begin failures++; $display("FAIL basic_timeout: no valid pulse within budget"); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (a[i] !== ref_addr(32'h0, i)) begin
                failures++;
                $display("FAIL basic_addr%0d: got %0d want %0d", i, a[i], ref_addr(32'h0, i));
            end
        end
        checks++;
        if (w !== 32'h20030008) begin failures++; $display("FAIL basic_word: got %h want 20030008", w); end
        checks++;
        if (lat !== 5) begin failures++; $display("FAIL basic_latency: got %0d want 5", lat); end
        checks++;
        if (bn !== 5) begin failures++; $display("FAIL basic_busy_cycles: got %0d want 5", bn); end
        tick();
        checks++;
        if (valid !== 1'b0) begin failures++; $display("FAIL basic_valid_width: valid=%b want 0", valid); end
    endtask

    task automatic test_wrap();
        logic [31:0] w; int lat, bn; logic [3:0][ADDR_W-1:0] a; bit got;
        logic [31:0] pcs [2];
        logic [31:0] exp_w [2];
        pcs[0] = 32'h3C; exp_w[0] = 32'ha00400ff;
        pcs[1] = 32'h40; exp_w[1] = 32'h20030008;
        for (int t = 0; t < 2; t++) begin
            do_fetch(pcs[t], 1'b0, w, lat, bn, a, got);
            checks++;
            if (w !== exp_w[t] || !got) begin
                failures++;
                $display("FAIL wrap_word pc=%h: got %h (valid seen %0d) want %h", pcs[t], w, got, exp_w[t]);
            end
            checks++;
            if (a !== {ref_addr(pcs[t], 3), ref_addr(pcs[t], 2), ref_addr(pcs[t], 1), ref_addr(pcs[t], 0)}) begin
                failures++;
                $display("FAIL wrap_addrs pc=%h: got %h want %0d..%0d", pcs[t], a,
                         ref_addr(pcs[t], 0), ref_addr(pcs[t], 3));
            end
            tick();
        end
    endtask

    task automatic test_misalign();
        logic [ADDR_W-1:0] a0; logic [31:0] i0; bit bad;
        a0 = mem_addr; i0 = instr;
        fetch_req = 1'b1; pc = 32'h2;
        tick();
        fetch_req = 1'b0;
        checks++;
        if (misalign !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL misalign_pulse: misalign=%b busy=%b want 1/0", misalign, busy);
        end
        checks++;
        if (mem_addr !== a0) begin failures++; $display("FAIL misalign_addr: got %0d want %0d", mem_addr, a0); end
        bad = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (misalign || valid || busy) bad = 1'b1;
        end
        checks++;
        if (bad !== 1'b0 || instr !== i0) begin
            failures++;
            $display("FAIL misalign_after: stray activity=%b instr=%h want quiet, instr %h", bad, instr, i0);
        end
        // Flush together with a request in IDLE drops the request.
        flush = 1'b1; fetch_req = 1'b1; pc = 32'h8;
        tick();
        flush = 1'b0; fetch_req = 1'b0;
        bad = busy | misalign;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (valid || busy) bad = 1'b1;
        end
        checks++;
        if (bad !== 1'b0) begin failures++; $display("FAIL idle_flush_req: activity=%b want 0", bad); end
    endtask

    task automatic test_flush();
        logic [31:0] prev, w; int lat, bn; logic [3:0][ADDR_W-1:0] a; bit got, seen;
        prev = instr;
        fetch_req = 1'b1; pc = 32'h10;
        tick();                 // after E0
        fetch_req = 1'b0;
        tick(); tick();         // after E1, E2
        flush = 1'b1;
        tick();                 // E3 samples flush
        flush = 1'b0;
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL flush_busy: busy=%b want 0", busy); end
        seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (valid) seen = 1'b1;
            tick();
        end
        checks++;
        if (seen !== 1'b0 || instr !== prev) begin
            failures++;
            $display("FAIL flush_no_valid: valid seen=%b instr=%h want 0, %h", seen, instr, prev);
        end
        do_fetch(32'h4, 1'b0, w, lat, bn, a, got);
        checks++;
        if (w !== 32'h20040001 || lat !== 5) begin
            failures++;
            $display("FAIL flush_refetch: got %h lat %0d want 20040001 lat 5", w, lat);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_w [3];
        int nv, last, c;
        bit bad;
        exp_w[0] = 32'h20030008; exp_w[1] = 32'h20040001; exp_w[2] = 32'h2005ffff;
        nv = 0; last = 0; c = 0; bad = 1'b0;
        fetch_req = 1'b1; pc = 32'h0;
        tick();
        while (nv < 3 && c < 40) begin
            if (valid) begin
                checks++;
                if (instr !== exp_w[nv]) begin
                    failures++;
                    $display("FAIL b2b_word%0d: got %h want %h", nv, instr, exp_w[nv]);
                end
                checks++;
                if (c - last !== ((nv == 0) ? 5 : 6)) begin
                    failures++;
                    $display("FAIL b2b_interval%0d: got %0d want %0d", nv, c - last, (nv == 0) ? 5 : 6);
                end
                if (busy) bad = 1'b1;
                last = c;
                nv++;
                pc = pc + 32'd4;
                if (nv == 3) fetch_req = 1'b0;
            end else if (!busy) begin
                bad = 1'b1;
            end
            if (nv < 3) begin
                tick();
                c++;
            end
        end
        fetch_req = 1'b0;
        checks++;
        if (nv !== 3 || bad !== 1'b0) begin
            failures++;
            $display("FAIL b2b_stream: pulses=%0d busy_gap=%b want 3, 0", nv, bad);
        end
        tick();
    endtask

    task automatic test_random();
        logic [31:0] p, w; int lat, bn; logic [3:0][ADDR_W-1:0] a; bit got, ok;
        for (int i = 0; i < MEM_SZ; i++) mem[i] = 8'($urandom);
        for (int n = 0; n < 24; n++) begin
            p = $urandom;
            if ($urandom_range(0, 3) == 0) begin
                if (p[1:0] == 2'b00) p[0] = 1'b1;
                fetch_req = 1'b1; pc = p;
                tick();
                fetch_req = 1'b0;
                checks++;
                if (misalign !== 1'b1 || busy !== 1'b0) begin
                    failures++;
                    $display("FAIL rand_misalign pc=%h: misalign=%b busy=%b want 1/0", p, misalign, busy);
                end
                tick();
            end else begin
                p[1:0] = 2'b00;
                do_fetch(p, 1'b1, w, lat, bn, a, got);
                ok = 1'b1;
                for (int i = 0; i < 4; i++) if (a[i] !== ref_addr(p, i)) ok = 1'b0;
                checks++;
                if (!got || w !== ref_word(p) || lat !== 5 || !ok) begin
                    failures++;
                    $display("FAIL rand_fetch pc=%h: got %h lat %0d addrs_ok %0d want %h lat 5",
                             p, w, lat, ok, ref_word(p));
                end
                tick();
            end
        end
    endtask

    task automatic test_async_reset();
        logic [31:0] w; int lat, bn; logic [3:0][ADDR_W-1:0] a; bit got, seen;
        do_fetch(32'h0, 1'b0, w, lat, bn, a, got);
        tick();
        fetch_req = 1'b1; pc = 32'h8;
        tick();
        fetch_req = 1'b0;
        tick(); tick();
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({mem_addr, instr, valid, busy, misalign} !== '0) begin
            failures++;
            $display("FAIL async_reset: addr=%0d instr=%h v=%b b=%b m=%b, want all 0",
                     mem_addr, instr, valid, busy, misalign);
        end
        #3;
        rst = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (valid || busy) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin failures++; $display("FAIL async_reset_after: activity=%b want 0", seen); end
        do_fetch(32'h4, 1'b0, w, lat, bn, a, got);
        checks++;
        if (!got || w !== ref_word(32'h4)) begin
            failures++;
            $display("FAIL async_reset_refetch: got %h want %h", w, ref_word(32'h4));
        end
    endtask

    initial begin
        init_mem();
        test_reset();
        test_basic();
        test_wrap();
        test_misalign();
        test_flush();
        test_back_to_back();
        test_random();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
